row_ring_buffer: RTL and testbench

//  N-bank successor of the two-bank ping-pong row store. Writer fills one row per bank

---
 rtl/row_ring_buffer_pkg.sv | 16 +
 rtl/row_ring_buffer_row_bank.sv | 27 ++
 rtl/row_ring_buffer.sv | 88 ++++++++
 tb/tb_row_ring_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/row_ring_buffer_pkg.sv
// Shared helpers for the row ring buffer: bank-pointer width calculation.
package row_ring_buffer_pkg;

  function automatic int clog2(input int unsigned value);
    int unsigned v;
    int result;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/row_ring_buffer_row_bank.sv
// One row bank: synchronous write, registered read (read-before-write on same address).
module row_bank #(
  parameter int A = 9,
  parameter int S = 24
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [S-1:0] wr_data,
  input  logic [A-1:0] rd_addr,
  output logic [S-1:0] rd_data
);

  logic [S-1:0] mem [2**A];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the output register resets; stored words survive reset.
  always_ff @(posedge clock) begin
    if (!nreset) rd_data <= '0;
    else         rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/row_ring_buffer.sv
// B-bank row ring buffer: writer commits whole rows, reader releases them in order.
module row_ring_buffer
  import row_ring_buffer_pkg::*;
#(
  parameter int  A  = 9,
  parameter int  S  = 24,
  parameter int  B  = 3,
  localparam int BW = clog2(B)
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [S-1:0] wr_data,
  input  logic         wr_done,
  output logic         wr_ready,
  input  logic [A-1:0] rd_addr,
  output logic [S-1:0] rd_data,
  input  logic         rd_done,
  output logic         rd_ready,
  output logic [BW:0]  rows_ready,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [BW:0]   FULL = (BW+1)'(B);
  localparam logic [BW-1:0] LAST = BW'(B-1);

  logic [BW-1:0] wr_ptr;
  logic [BW-1:0] rd_ptr;
  logic [BW-1:0] rd_sel;
  logic [BW:0]   count;
  logic          full;
  logic          empty;
  logic          wr_accept;
  logic          commit_ok;
  logic          rel_ok;
  logic [S-1:0]  bank_q [B];

  // Legality is judged on the pre-edge count, so a release cannot make room for a same-cycle commit.
  assign full      = (count == FULL);
  assign empty     = (count == '0);
  assign wr_accept = nreset & wr_en & ~full;
  assign commit_ok = wr_done & ~full;
  assign rel_ok    = rd_done & ~empty;

  assign wr_ready   = ~full;
  assign rd_ready   = ~empty;
  assign rows_ready = count;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_sel    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_sel <= rd_ptr;
      if (commit_ok) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (rel_ok)    rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({commit_ok, rel_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (full && (wr_en || wr_done)) overflow  <= 1'b1;
      if (empty && rd_done)           underflow <= 1'b1;
    end
  end

  for (genvar i = 0; i < B; i++) begin : g_bank
    row_bank #(.A(A), .S(S)) u_bank (
      .clock   (clock),
      .nreset  (nreset),
      .wr_en   (wr_accept && (wr_ptr == BW'(i))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (bank_q[i])
    );
  end

  // rd_sel lags rd_ptr by one cycle to line up with the bank output register.
  assign rd_data = bank_q[rd_sel];

endmodule

// File: tb/tb_row_ring_buffer.sv
// Directed plus random bench for row_ring_buffer against a row-queue reference model.
module tb_row_ring_buffer;

  localparam int A  = 9;
  localparam int S  = 24;
  localparam int B  = 3;
  localparam int BW = $clog2(B);

  logic         clock = 1'b0;
  logic         nreset;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [S-1:0] wr_data;
  logic         wr_done;
  logic         wr_ready;
  logic [A-1:0] rd_addr;
  logic [S-1:0] rd_data;
  logic         rd_done;
  logic         rd_ready;
  logic [BW:0]  rows_ready;
  logic         overflow;
  logic         underflow;

  always #5 clock = ~clock;

  row_ring_buffer #(.A(A), .S(S), .B(B)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_done    (wr_done),
    .wr_ready   (wr_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_done    (rd_done),
    .rd_ready   (rd_ready),
    .rows_ready (rows_ready),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // Reference model: banks as plain arrays, rows tracked as write/read bank indices plus a count.
  logic [S-1:0] m_mem   [B][2**A];
  bit           m_known [B][2**A];
  int           m_wr, m_rd, m_cnt;
  bit           m_ovf, m_unf;
  logic [S-1:0] m_rdata;
  bit           m_rvalid;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_update(input logic we, input logic [A-1:0] wa, input logic [S-1:0] wd,
                              input logic wdn, input logic [A-1:0] ra, input logic rdn,
                              input logic rst_n);
    bit was_full, was_empty;
    if (!rst_n) begin
      m_wr = 0; m_rd = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
      m_rdata = '0; m_rvalid = 1;
      return;
    end
    was_full  = (m_cnt == B);
    was_empty = (m_cnt == 0);
    m_rdata  = m_mem[m_rd][ra];
    m_rvalid = m_known[m_rd][ra];
    if (we) begin
      if (was_full) m_ovf = 1;
      else begin
        m_mem[m_wr][wa]   = wd;
        m_known[m_wr][wa] = 1;
      end
    end
    if (wdn) begin
      if (was_full) m_ovf = 1;
      else begin
        m_wr = (m_wr + 1) % B;
        m_cnt++;
      end
    end
    if (rdn) begin
      if (was_empty) m_unf = 1;
      else begin
        m_rd = (m_rd + 1) % B;
        m_cnt--;
      end
    end
  endtask

  task automatic step(input logic we, input logic [A-1:0] wa, input logic [S-1:0] wd,
                      input logic wdn, input logic [A-1:0] ra, input logic rdn,
                      input logic rst_n);
    nreset = rst_n; wr_en = we; wr_addr = wa; wr_data = wd;
    wr_done = wdn; rd_addr = ra; rd_done = rdn;
    @(posedge clock);
    model_update(we, wa, wd, wdn, ra, rdn, rst_n);
    #1;
    chk("rows_ready", 32'(rows_ready), 32'(m_cnt));
    chk("wr_ready", 32'(wr_ready), 32'(m_cnt < B));
    chk("rd_ready", 32'(rd_ready), 32'(m_cnt > 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    if (m_rvalid) chk("rd_data", 32'(rd_data), 32'(m_rdata));
  endtask

  task automatic write_word(input logic [A-1:0] a, input logic [S-1:0] d);
    step(1, a, d, 0, '0, 0, 1);
  endtask

  task automatic commit_row();
    step(0, '0, '0, 1, '0, 0, 1);
  endtask

  task automatic release_row();
    step(0, '0, '0, 0, '0, 1, 1);
  endtask

  task automatic read_word(input logic [A-1:0] a);
    step(0, '0, '0, 0, a, 0, 1);
  endtask

  initial begin
    m_rvalid = 0;
    m_wr = 0; m_rd = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;

    // Reset state
    step(0, '0, '0, 0, '0, 0, 0);
    step(0, '0, '0, 0, '0, 0, 0);
    chk("reset_rows", 32'(rows_ready), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);

    // 1: fill one row and read it back
    for (int unsigned i = 0; i < 4; i++) write_word(A'(i), S'(24'h10 + i));
    commit_row();
    read_word(2);
    chk("t1_rd_data", 32'(rd_data), 32'h12);
    chk("t1_rows", 32'(rows_ready), 32'd1);
    chk("t1_rd_ready", 32'(rd_ready), 32'd1);

    // 2: fill to capacity, then an extra write must be dropped
    write_word(0, 24'h111);
    commit_row();
    write_word(0, 24'h222);
    commit_row();
    chk("t2_wr_ready", 32'(wr_ready), 32'd0);
    write_word(0, 24'hDEAD);
    chk("t2_overflow", 32'(overflow), 32'd1);
    read_word(0);
    chk("t2_row_intact", 32'(rd_data), 32'h10);

    // 3: drain, then release while empty
    release_row(); release_row(); release_row();
    release_row();
    chk("t3_underflow", 32'(underflow), 32'd1);
    write_word(7, 24'h77);
    commit_row();
    read_word(7);
    chk("t3_bank0_read", 32'(rd_data), 32'h77);

    // 4: simultaneous commit+release at one row, across a wrap
    for (int unsigned i = 0; i <= B; i++) begin
      write_word(9, S'(24'h900 + i));
      step(0, '0, '0, 1, 9, 1, 1);
      chk("t4_rows", 32'(rows_ready), 32'd1);
      read_word(9);
      chk("t4_advance", 32'(rd_data), 32'(24'h900 + i));
    end

    // 5: reset with two rows committed
    write_word(3, 24'h333);
    commit_row();
    chk("t5_rows_pre", 32'(rows_ready), 32'd2);
    step(0, '0, '0, 0, '0, 0, 0);
    chk("t5_rows", 32'(rows_ready), 32'd0);
    chk("t5_rd_data", 32'(rd_data), 32'd0);
    chk("t5_flags", 32'({overflow, underflow}), 32'd0);
    write_word(1, 24'hBEEF);
    commit_row();
    read_word(1);
    chk("t5_readback", 32'(rd_data), 32'hBEEF);
    read_word(2);
    chk("t5_persist", 32'(rd_data), 32'h12);

    // 6: read-before-write at count==0
    release_row();
    write_word(5, 24'h55);
    step(1, 5, 24'hAA, 0, 5, 0, 1);
    chk("t6_old", 32'(rd_data), 32'h55);
    read_word(5);
    chk("t6_new", 32'(rd_data), 32'hAA);

    // Random traffic over a small address window so reads mostly hit known words
    for (int unsigned n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)), A'($urandom_range(0, 15)), S'($urandom),
           1'($urandom_range(0, 3) == 0), A'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 99) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
